// File: rtl/vga_rect_plotter.sv
// Rectangle pixel engine for the DESim VGA port: takes one fill/outline/clear
// command at a time and emits one pixel per clock in row-major order, clipped to the screen.
module vga_rect_plotter #(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [X_W-1:0]     VGA_X,
  output logic [Y_W-1:0]     VGA_Y,
  output logic [COLOR_W-1:0] VGA_COLOR,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t st, st_nx;

  logic [X_W-1:0]     x_q, w_q, dx, nxt_dx;
  logic [Y_W-1:0]     y_q, h_q, dy, nxt_dy;
  logic [COLOR_W-1:0] col_q;
  logic               outline_q;

  logic               is_clr, load, px_vld, last, nxt_plot, on_scr, sel;
  logic [X_W-1:0]     eff_x, eff_w, src_x, src_w;
  logic [Y_W-1:0]     eff_y, eff_h, src_y, src_h;
  logic [COLOR_W-1:0] src_col;
  logic               src_outline;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;

  always_comb begin
    is_clr = (cmd_mode == 2'd2);
    eff_x  = is_clr ? '0 : cmd_x;
    eff_y  = is_clr ? '0 : cmd_y;
    eff_w  = is_clr ? X_W'(SCREEN_W) : cmd_w;
    eff_h  = is_clr ? Y_W'(SCREEN_H) : cmd_h;
    last   = (dx == w_q - X_W'(1)) && (dy == h_q - Y_W'(1));

    st_nx  = st;
    nxt_dx = dx;
    nxt_dy = dy;
    load   = 1'b0;
    px_vld = 1'b0;
    case (st)
      IDLE: if (cmd_valid) begin
        load   = 1'b1;
        nxt_dx = '0;
        nxt_dy = '0;
        if (eff_w == '0 || eff_h == '0) begin
          st_nx = DONE;
        end else begin
          st_nx  = DRAW;
          px_vld = 1'b1;
        end
      end
      DRAW: if (last) begin
        st_nx = DONE;
      end else begin
        px_vld = 1'b1;
        if (dx == w_q - X_W'(1)) begin
          nxt_dx = '0;
          nxt_dy = dy + Y_W'(1);
        end else begin
          nxt_dx = dx + X_W'(1);
        end
      end
      DONE: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase

    // The pixel registered this edge comes from the live command on accept,
    // otherwise from the latched copy.
    src_x       = load ? eff_x : x_q;
    src_y       = load ? eff_y : y_q;
    src_w       = load ? eff_w : w_q;
    src_h       = load ? eff_h : h_q;
    src_col     = load ? cmd_color : col_q;
    src_outline = load ? (cmd_mode == 2'd1) : outline_q;

    sum_x    = {1'b0, src_x} + {1'b0, nxt_dx};
    sum_y    = {1'b0, src_y} + {1'b0, nxt_dy};
    on_scr   = (sum_x < SCR_W) && (sum_y < SCR_H);
    sel      = !src_outline || nxt_dx == '0 || nxt_dx == src_w - X_W'(1) ||
               nxt_dy == '0 || nxt_dy == src_h - Y_W'(1);
    nxt_plot = px_vld && on_scr && sel;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      outline_q <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      st   <= st_nx;
      dx   <= nxt_dx;
      dy   <= nxt_dy;
      plot <= nxt_plot;
      busy <= (st_nx != IDLE);
      done <= (st_nx == DONE);
      if (load) begin
        x_q       <= eff_x;
        y_q       <= eff_y;
        w_q       <= eff_w;
        h_q       <= eff_h;
        col_q     <= cmd_color;
        outline_q <= (cmd_mode == 2'd1);
      end
      if (px_vld) begin
        VGA_X     <= sum_x[X_W-1:0];
        VGA_Y     <= sum_y[Y_W-1:0];
        VGA_COLOR <= src_col;
      end
    end
  end

  // Ready comes straight off the state register, gated so it reads 0 during reset.
  assign cmd_ready = !reset && (st == IDLE);

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Randomised bench for vga_rect_plotter: each command's pixel stream is predicted
// from the rectangle rules with plain arithmetic and compared cycle by cycle.
module tb_vga_rect_plotter;

  localparam int SW = 64;
  localparam int SH = 48;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = '0;
  logic [9:0] cmd_x = '0;
  logic [8:0] cmd_y = '0;
  logic [9:0] cmd_w = '0;
  logic [8:0] cmd_h = '0;
  logic [2:0] cmd_color = '0;
  logic [9:0] VGA_X;
  logic [8:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot, busy, done;

  int n_chk = 0;
  int n_err = 0;

  vga_rect_plotter #(.X_W(10), .Y_W(9), .COLOR_W(3), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // {x, y, colour, plot, busy, done, ready}
  function automatic logic [31:0] obs();
    return {6'b0, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done, cmd_ready};
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Issue one command and check every cycle up to the return to idle.
  task automatic run_cmd(input int mode, input int x, input int y, input int w,
                         input int h, input int col, input bit hold);
    int ex, ey, ew, eh, dx, dy;
    bit pl;
    cmd_mode  = 2'(mode);
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = 3'(col);
    cmd_valid = 1'b1;
    chk("ready_before", {31'b0, cmd_ready}, 32'd1);
    tick();
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_mode  = 2'($urandom);
      cmd_x     = 10'($urandom);
      cmd_y     = 9'($urandom);
      cmd_w     = 10'($urandom);
      cmd_h     = 9'($urandom);
      cmd_color = 3'($urandom);
    end
    ex = (mode == 2) ? 0 : x;
    ey = (mode == 2) ? 0 : y;
    ew = (mode == 2) ? SW : w;
    eh = (mode == 2) ? SH : h;
    for (int i = 0; i < ew * eh; i++) begin
      dx = i % ew;
      dy = i / ew;
      pl = (ex + dx < SW) && (ey + dy < SH) &&
           (mode != 1 || dx == 0 || dx == ew - 1 || dy == 0 || dy == eh - 1);
      chk("pixel", obs(), {6'b0, 10'(ex + dx), 9'(ey + dy), 3'(col), pl, 1'b1, 1'b0, 1'b0});
      tick();
    end
    chk("done_cycle", obs() & 32'hF, 32'b0110);
    tick();
    chk("idle_after", obs() & 32'hF, 32'b0001);
  endtask

  initial begin
    int m;
    #1 reset = 1'b1;
    #2 chk("reset_state", obs(), 32'd0);
    tick();
    tick();
    chk("reset_hold", obs(), 32'd0);
    reset = 1'b0;
    #1 chk("reset_release", obs(), 32'd1);
    tick();

    run_cmd(0, 10, 20, 3, 2, 5, 1'b0);
    run_cmd(1, 0, 0, 4, 4, 2, 1'b0);
    run_cmd(0, SW - 2, SH - 2, 4, 3, 6, 1'b0);
    run_cmd(0, 1022, 5, 4, 2, 1, 1'b0);
    run_cmd(1, 3, 3, 1, 5, 4, 1'b0);
    run_cmd(1, 7, 2, 6, 1, 3, 1'b0);
    run_cmd(1, 8, 8, 2, 2, 7, 1'b0);
    run_cmd(2, 17, 9, 0, 3, 0, 1'b0);
    run_cmd(0, 4, 4, 0, 5, 2, 1'b0);
    run_cmd(3, 4, 4, 5, 0, 2, 1'b0);
    // valid held high: one acceptance per ready window, back to back
    run_cmd(0, 30, 31, 2, 2, 5, 1'b1);
    run_cmd(0, 30, 31, 2, 2, 5, 1'b0);

    for (int k = 0; k < 40; k++) begin
      m = $urandom_range(0, 2);
      if (m == 2) m = 3;
      run_cmd(m, $urandom_range(0, SW + 4), $urandom_range(0, SH + 4),
              $urandom_range(0, 8), $urandom_range(0, 6), $urandom_range(0, 7), 1'b0);
    end

    // reset in the third cycle of a 4x4 fill
    cmd_mode = 2'd0; cmd_x = 10'd5; cmd_y = 9'd5; cmd_w = 10'd4; cmd_h = 9'd4;
    cmd_color = 3'd7; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("abort_px0", obs(), {6'b0, 10'd5, 9'd5, 3'd7, 4'b1100});
    tick();
    chk("abort_px1", obs(), {6'b0, 10'd6, 9'd5, 3'd7, 4'b1100});
    tick();
    #2 reset = 1'b1;
    #1 chk("abort_async", obs(), 32'd0);
    tick();
    tick();
    chk("abort_hold", obs(), 32'd0);
    reset = 1'b0;
    #1 chk("abort_release", obs(), 32'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("no_done_after_abort", obs() & 32'hF, 32'b0001);
    end
    run_cmd(0, 3, 4, 1, 1, 6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_rect_plotter.md
Name: vga_rect_plotter

Overview:
- Parametrised pixel-drawing engine for the DESim VGA path. It drives the `VGA_X`/`VGA_Y`/`VGA_COLOR`/`plot` interface directly.
- Accepts one rectangle command at a time over a valid/ready handshake. Emits one pixel per clock in row-major order.
- Supports filled rectangle, outline rectangle and full-screen clear, with screen-edge clipping.
- Replaces hand-written per-demo plot counters. Sits between user control logic and the board-level VGA ports in `top`.

Parameters:
- X_W, 10, width of X coordinate, width field and `VGA_X`.
- Y_W, 9, width of Y coordinate, height field and `VGA_Y`.
- COLOR_W, 3, width of colour field and `VGA_COLOR`.
- SCREEN_W, 640, visible columns; pixels with X >= SCREEN_W are clipped.
- SCREEN_H, 480, visible rows; pixels with Y >= SCREEN_H are clipped.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_mode  in  2  0=fill, 1=outline, 2=clear, 3=reserved (treated as fill).
- cmd_x  in  X_W  left column.
- cmd_y  in  Y_W  top row.
- cmd_w  in  X_W  width in pixels.
- cmd_h  in  Y_W  height in pixels.
- cmd_color  in  COLOR_W  pixel colour.
- VGA_X  out  X_W  pixel column.
- VGA_Y  out  Y_W  pixel row.
- VGA_COLOR  out  COLOR_W  pixel colour.
- plot  out  1  pixel write strobe, one cycle per pixel.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - `cmd_ready`=1 once reset is deasserted; it is 0 while reset is asserted.
  - `VGA_X`=0, `VGA_Y`=0, `VGA_COLOR`=0, `plot`=0, `busy`=0, `done`=0, dx=dy=0.
  - Reset asserted mid-command aborts it immediately. No `done` pulse is produced.
- All outputs are registered. The state machine has three states: IDLE, DRAW, DONE.
- IDLE:
  - `cmd_ready`=1, `plot`=0.
  - On `cmd_valid`&&`cmd_ready` at an edge, latch all cmd_* fields and clear dx, dy.
  - Mode 2 replaces x,y,w,h with 0, 0, SCREEN_W, SCREEN_H.
  - If the latched w==0 or h==0, go to DONE. Otherwise go to DRAW.
- DRAW:
  - `cmd_ready`=0. Each cycle the outputs present pixel (x+dx, y+dy) with the latched colour.
  - The first pixel (dx=0, dy=0) is on the outputs in the cycle immediately after the accepting edge.
  - Scan order: dx counts 0..w-1. At dx==w-1, dx returns to 0 and dy increments.
  - After the pixel dx==w-1, dy==h-1 is presented, go to DONE. DRAW therefore lasts exactly w*h cycles.
- `plot` in DRAW is 1 only if both of these hold:
  - The pixel is on-screen: x+dx < SCREEN_W and y+dy < SCREEN_H. Sums are computed at X_W+1 / Y_W+1 bits, so there is no wrap-around.
  - It is selected by mode: fill/clear select every pixel; outline selects only dx==0, dx==w-1, dy==0 or dy==h-1.
- Clipped or unselected pixels still consume a cycle. `VGA_X`/`VGA_Y` show the truncated coordinate with `plot`=0.
- DONE:
  - Lasts one cycle: `done`=1, `plot`=0, `busy`=1, `cmd_ready`=0.
  - Next state is IDLE, with `cmd_ready`=1.
  - Minimum command-to-command spacing is therefore w*h+2 cycles.
- `cmd_valid` during DRAW/DONE is ignored (not latched). Changes on the cmd_* inputs after acceptance have no effect.
- Outline with w==1 or h==1 plots every pixel. Outline with w==2 and h==2 plots all 4 pixels.

Test Plan:
- Reset, then fill x=10 y=20 w=3 h=2 colour=5 -> `plot` high for 6 consecutive cycles starting the cycle after accept. Coordinates are (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), `VGA_COLOR`=5. `done` pulses on the next cycle, and `cmd_ready`=1 the cycle after that.
- Outline x=0 y=0 w=4 h=4 colour=2 -> 16 DRAW cycles with 12 `plot` pulses. Pixels (1,1)(2,1)(1,2)(2,2) are presented with `plot`=0.
- Fill x=638 y=478 w=4 h=3 -> 12 DRAW cycles. `plot`=1 only for (638,478)(639,478)(638,479)(639,479); the other 8 pixels show `plot`=0.
- Clear colour=0 with arbitrary x/y/w/h -> 307200 consecutive `plot` pulses covering (0,0)..(639,479), then one `done` pulse.
- w=0 h=5 -> no `plot`, `done` pulses 1 cycle after accept. Also hold `cmd_valid`=1 throughout a 2x2 fill and check that only one command is accepted per `cmd_ready` window.
- Assert reset during cycle 3 of a 4x4 fill -> `plot`, `busy` and `done` drop to 0 immediately, and no `done` pulse follows. After reset is released, a new 1x1 command draws exactly one pixel.
